// File: rtl/mul_nnbit_s01_abs_itera.sv
// Iterative shift-add multiplier (signed/unsigned), one multiplier bit per cycle on |x|*|y|.
// Optional MUL_EARLY_TERM_EN: stop CALC once no multiplier bits remain.
module mul_nnbit_s01_abs_itera #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic                      i_signed,
    input  logic [DATA_WIDTH-1:0]     i_num_x,
    input  logic [DATA_WIDTH-1:0]     i_num_y,
    output logic                      o_ready,
    output logic [2*DATA_WIDTH-1:0]   o_res,
    output logic                      o_valid
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   mcand, acc, acc_n;
    logic [W-1:0]    mplr, abs_x, abs_y;
    logic [CW-1:0]   cnt;
    logic            neg, accept, last;

    // Magnitudes as W-bit unsigned: -2^(W-1) maps to 2^(W-1) without overflow.
    assign abs_x  = (i_signed & i_num_x[W-1]) ? W'(-i_num_x) : i_num_x;
    assign abs_y  = (i_signed & i_num_y[W-1]) ? W'(-i_num_y) : i_num_y;
    assign accept = i_valid & o_ready;
    assign acc_n  = acc + (mplr[0] ? mcand : '0);

`ifdef MUL_EARLY_TERM_EN
    assign last = (cnt == CW'(W - 1)) || ((mplr >> 1) == '0);
`else
    assign last = (cnt == CW'(W - 1));
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = CALC;
            CALC:    if (last)   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            o_res   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= (state == CALC) && last;
            if (accept) begin
                mcand <= {{W{1'b0}}, abs_x};
                mplr  <= abs_y;
                acc   <= '0;
                cnt   <= '0;
                neg   <= i_signed & (i_num_x[W-1] ^ i_num_y[W-1]);
            end else if (state == CALC) begin
                acc   <= acc_n;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt + 1'b1;
                // Sign is applied only once, on the final accumulate.
                if (last) o_res <= neg ? PW'(-acc_n) : acc_n;
            end
        end
    end
endmodule
